// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared FSM state type and I2C bit-level constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_cond.sv
// ============================================================================
// i2c_bus_cond : SCL/SDA synchronizers, SCL edge pulses, START/STOP detect
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_bus_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s_o,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Flops reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s_o    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s_o    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s_o & ~scl_prev_q;
  assign scl_fall_o = ~scl_s_o & scl_prev_q;
  assign start_o    = scl_s_o & scl_prev_q & sda_prev_q & ~sda_s_o;
  assign stop_o     = scl_s_o & scl_prev_q & ~sda_prev_q & sda_s_o;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// i2c_target : oversampling I2C target with byte-stream write and read ports
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR    = 7'h2a,
  parameter int         SYNC_STAGES = 2,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       tx_underrun
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic scl_s, sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_bus_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_s_o    (scl_s),
    .sda_s_o    (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d, shift_in;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d, mack_q, mack_d;
  logic          rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic          start_det_q, start_det_d, stop_det_q, stop_det_d;
  logic          tx_underrun_q, tx_underrun_d;
  logic          upd, tx_load;

  // Drive point: hold time after a filtered SCL fall, and only while SCL is low.
  assign upd      = (hold_q == HW'(1)) && !scl_s;
  assign shift_in = {shift_q[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      hold_q        <= '0;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      rw_q          <= 1'b0;
      mack_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      start_det_q   <= 1'b0;
      stop_det_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      hold_q        <= hold_d;
      sda_oe_q      <= sda_oe_d;
      busy_q        <= busy_d;
      rw_q          <= rw_d;
      mack_q        <= mack_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      start_det_q   <= start_det_d;
      stop_det_q    <= stop_det_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    sda_oe_d      = sda_oe_q;
    busy_d        = busy_q;
    rw_d          = rw_q;
    mack_d        = mack_q;
    rx_valid_d    = 1'b0;
    tx_ready_d    = 1'b0;
    start_det_d   = 1'b0;
    stop_det_d    = 1'b0;
    tx_underrun_d = 1'b0;
    tx_load       = 1'b0;

    if (scl_fall)            hold_d = HW'(HOLD_CYCLES);
    else if (hold_q != '0)   hold_d = hold_q - HW'(1);
    else                     hold_d = hold_q;

    if (stop) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      start_det_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = sda_s;
            state_d = (shift_in[7:1] == TGT_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
        // ACK states: first drive point pulls SDA, second releases it.
        ADDR_ACK, WR_ACK: if (upd) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
            tx_load = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            state_d    = WR_ACK;
          end
        end
        RD_DATA: if (upd) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            mack_d   = 1'b0;
            state_d  = RD_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) mack_d  = 1'b1;
            else                  state_d = IGNORE;
          end else if (upd && mack_q) begin
            tx_load = 1'b1;
          end
        end
        default: ;
      endcase

      // A load also drives the first (MSB) data bit at the same drive point.
      if (tx_load) begin
        tx_ready_d = 1'b1;
        state_d    = RD_DATA;
        bit_cnt_d  = '0;
        if (tx_valid) begin
          shift_d = tx_data;
        end else begin
          shift_d       = 8'hFF;
          tx_underrun_d = 1'b1;
        end
        sda_oe_d = ~shift_d[7];
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign start_det   = start_det_q;
  assign stop_det    = stop_det_q;
  assign tx_underrun = tx_underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// tb_i2c_target : controller BFM (~400 kHz SCL) with queue-based scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_target;

  localparam int TQ = 620;  // quarter SCL period in ns (clk period 10 ns)

  logic       clk, rst_n, scl_c, sda_c;
  logic       sda_w;
  logic       sda_oe, rx_valid, tx_ready, busy, start_det, stop_det, tx_underrun;
  logic [7:0] rx_data, tx_data;
  logic       tx_valid;

  assign sda_w = sda_c & ~sda_oe;

  i2c_target dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl_c),
    .sda_i       (sda_w),
    .sda_oe      (sda_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .start_det   (start_det),
    .stop_det    (stop_det),
    .tx_underrun (tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int c_start = 0, c_stop = 0, c_rxv = 0, c_txr = 0, c_und = 0, c_oe = 0, oe_viol = 0;
  int b_start, b_stop, b_rxv, b_txr, b_und, b_oe;

  logic [7:0] exp_rx[$], exp_rd[$], act_rd[$], exp_ack[$], act_ack[$], tx_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pair_check(input string nm, inout logic [7:0] a[$], inout logic [7:0] e[$]);
    while (a.size() > 0) begin
      if (e.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL %s: got %0h expected nothing", nm, a.pop_front());
      end else begin
        chk(nm, {24'd0, a.pop_front()}, {24'd0, e.pop_front()});
      end
    end
  endtask

  task automatic monitor_step();
    if (rst_n) begin
      if (start_det)   c_start++;
      if (stop_det)    c_stop++;
      if (tx_underrun) c_und++;
      if (sda_oe)      c_oe++;
      if (tx_ready) begin
        c_txr++;
        if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      end
      if (rx_valid) begin
        c_rxv++;
        if (exp_rx.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rx_data: got %0h expected no rx_valid", rx_data);
        end else begin
          chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
        end
      end
    end
    pair_check("ack", act_ack, exp_ack);
    pair_check("rd_byte", act_rd, exp_rd);
  endtask

  // Controller bit slot: SCL low, data at mid-low, sample at mid-high.
  task automatic clk_bit(input logic b, output logic s);
    scl_c = 1'b0; #TQ;
    sda_c = b;    #TQ;
    scl_c = 1'b1; #TQ;
    s = sda_w;    #TQ;
  endtask

  task automatic bus_start();
    sda_c = 1'b0; #(2*TQ);
  endtask

  task automatic bus_rstart();
    scl_c = 1'b0; #TQ;
    sda_c = 1'b1; #TQ;
    scl_c = 1'b1; #TQ;
    sda_c = 1'b0; #TQ;
  endtask

  task automatic bus_stop();
    scl_c = 1'b0; #TQ;
    sda_c = 1'b0; #TQ;
    scl_c = 1'b1; #TQ;
    sda_c = 1'b1; #(2*TQ);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_a);
    logic s;
    exp_ack.push_back({7'd0, exp_a});
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    act_ack.push_back({7'd0, s});
  endtask

  task automatic rd_byte(input logic [7:0] exp_b, input logic ack_bit);
    logic [7:0] b;
    logic s;
    exp_rd.push_back(exp_b);
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(ack_bit, s);
    act_rd.push_back(b);
  endtask

  task automatic snap();
    b_start = c_start; b_stop = c_stop; b_rxv = c_rxv;
    b_txr = c_txr; b_und = c_und; b_oe = c_oe;
  endtask

  initial begin
    rst_n = 1'b0; scl_c = 1'b1; sda_c = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0;
    fork
      forever begin @(negedge clk); monitor_step(); end
      begin : oe_watch
        logic prev_oe, prev_rst;
        prev_oe = 1'b0; prev_rst = 1'b0;
        forever begin
          @(posedge clk); #1;
          if (rst_n && prev_rst && sda_oe !== prev_oe && scl_c) oe_viol++;
          prev_oe = sda_oe; prev_rst = rst_n;
        end
      end
    join_none

    #40;
    chk("reset_outputs", {23'd0, sda_oe, rx_data, rx_valid, tx_ready, busy, start_det,
        stop_det, tx_underrun}, 32'd0);
    #60 rst_n = 1'b1;
    #200;

    // 1: write 0x74 to 0x2a
    snap();
    exp_rx.push_back(8'h74);
    bus_start();
    chk("t1_busy_high", {31'd0, busy}, 32'd1);
    wr_byte(8'h54, 1'b0);
    wr_byte(8'h74, 1'b0);
    bus_stop();
    chk("t1_start_cnt", c_start - b_start, 1);
    chk("t1_stop_cnt", c_stop - b_stop, 1);
    chk("t1_rxv_cnt", c_rxv - b_rxv, 1);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);

    // 2: read 0x5c, controller NACKs
    snap();
    tx_valid = 1'b1; tx_data = 8'h5c;
    bus_start();
    wr_byte(8'h55, 1'b0);
    rd_byte(8'h5c, 1'b1);
    chk("t2_oe_released", {31'd0, sda_oe}, 32'd0);
    bus_stop();
    chk("t2_txr_cnt", c_txr - b_txr, 1);
    chk("t2_und_cnt", c_und - b_und, 0);
    chk("t2_busy_low", {31'd0, busy}, 32'd0);

    // 3: wrong address 0x2b
    snap();
    bus_start();
    wr_byte(8'h56, 1'b1);
    bus_stop();
    chk("t3_oe_never", c_oe - b_oe, 0);
    chk("t3_rxv_cnt", c_rxv - b_rxv, 0);

    // 4: write 0x11, repeated START, read A0 (ACK) then A1 (NACK)
    snap();
    exp_rx.push_back(8'h11);
    tx_data = 8'hA0; tx_q.push_back(8'hA1);
    bus_start();
    wr_byte(8'h54, 1'b0);
    wr_byte(8'h11, 1'b0);
    bus_rstart();
    wr_byte(8'h55, 1'b0);
    rd_byte(8'hA0, 1'b0);
    rd_byte(8'hA1, 1'b1);
    bus_stop();
    chk("t4_start_cnt", c_start - b_start, 2);
    chk("t4_txr_cnt", c_txr - b_txr, 2);
    chk("t4_rxv_cnt", c_rxv - b_rxv, 1);

    // 5: read with no tx data available
    snap();
    tx_valid = 1'b0;
    bus_start();
    wr_byte(8'h55, 1'b0);
    rd_byte(8'hFF, 1'b1);
    bus_stop();
    chk("t5_und_cnt", c_und - b_und, 1);
    chk("t5_txr_cnt", c_txr - b_txr, 1);

    // 6: reset while the target pulls SDA for a read data bit
    tx_valid = 1'b1; tx_data = 8'h00;
    bus_start();
    wr_byte(8'h55, 1'b0);
    scl_c = 1'b0; #TQ;
    sda_c = 1'b1; #TQ;
    scl_c = 1'b1; #(TQ/2);
    chk("t6_oe_before_rst", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_oe_async_clear", {31'd0, sda_oe}, 32'd0);
    chk("t6_reset_outputs", {23'd0, sda_oe, rx_data, rx_valid, tx_ready, busy, start_det,
        stop_det, tx_underrun}, 32'd0);
    #199;
    rst_n = 1'b1;
    #200;
    snap();
    exp_rx.push_back(8'h74);
    bus_start();
    wr_byte(8'h54, 1'b0);
    wr_byte(8'h74, 1'b0);
    bus_stop();
    chk("t6_rxv_cnt", c_rxv - b_rxv, 1);
    chk("t6_stop_cnt", c_stop - b_stop, 1);

    #500;
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("ack_queue_drained", exp_ack.size(), 0);
    chk("oe_stable_scl_high", oe_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
